// File: rtl/trig_seq_pkg.sv
// ---------------------------------------------------------------------------
// trig_seq_pkg
//   Shared types for the APV trigger sequencer. It holds:
//   - the FSM state encoding,
//   - the trigger source indices (ext / sw / pulser),
//   - the fixed-priority source picker used by the arbiter.
// ---------------------------------------------------------------------------
package trig_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG_HI = 3'd1,
        ST_TRIG_LO = 3'd2,
        ST_RST_HI  = 3'd3,
        ST_RST_LO  = 3'd4
    } seq_state_t;

    localparam int NUM_SRC    = 3;
    localparam int SRC_EXT    = 0;
    localparam int SRC_SW     = 1;
    localparam int SRC_PULSER = 2;

    // Shortest low phase after any command, whatever MIN_SPACING says.
    localparam int MIN_LOW    = 2;

    typedef logic [1:0] src_id_t;

    // Fixed priority ext > sw > pulser. Only meaningful when pend != 0.
    function automatic src_id_t pick_src(input logic [NUM_SRC-1:0] pend);
        src_id_t id;
        id = src_id_t'(SRC_PULSER);
        if (pend[SRC_SW])  id = src_id_t'(SRC_SW);
        if (pend[SRC_EXT]) id = src_id_t'(SRC_EXT);
        return id;
    endfunction

endpackage

// File: rtl/trig_pulser.sv
// ---------------------------------------------------------------------------
// trig_pulser
//   Free-running period counter. It emits a one-cycle tick each time the
//   count reaches period-1, then reloads to 0. The counter is held at 0
//   while the pulser is disabled or the period is 0.
// Ports
//   gclk    in   clock
//   grst_n  in   async active-low reset
//   enable  in   pulser source enabled
//   period  in   period in gclk cycles, 0 = off
//   tick    out  one-cycle request strobe
// ---------------------------------------------------------------------------
module trig_pulser #(
    parameter int PULSER_W = 24
) (
    input  logic                gclk,
    input  logic                grst_n,
    input  logic                enable,
    input  logic [PULSER_W-1:0] period,
    output logic                tick
);

    logic [PULSER_W-1:0] cnt;
    logic                run;

    assign run = enable && (period != '0);

    // The >= comparison keeps the pulser alive if the period is lowered
    // below the current count. It ticks once, reloads, and resumes.
    assign tick = run && (cnt >= (period - PULSER_W'(1)));

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n)
            cnt <= '0;
        else if (!run || tick)
            cnt <= '0;
        else
            cnt <= cnt + PULSER_W'(1);
    end

endmodule

// File: rtl/apv_trig_sequencer.sv
// ---------------------------------------------------------------------------
// apv_trig_sequencer
//   Front-end scheduler for the APV trigger generator. It arbitrates three
//   trigger sources: external, software and internal pulser. It drives the
//   generator's TRIG_CMD / RESET_CMD edge inputs with a programmable high
//   time and a minimum low time. After every RESYNC_EVERY issued triggers,
//   it inserts a RESET_CMD. It counts issued and dropped requests.
// Ports
//   CLK, RSTb         clock, async active-low reset
//   SRC_EN[2:0]       per-source enable: [0] ext, [1] sw, [2] pulser
//   EXT_TRIG          asynchronous external level (2-FF synchronized here)
//   SW_TRIG           software trigger pulse
//   SW_RESET          software resync request pulse (never dropped)
//   PULSER_PERIOD     pulser period, 0 = off
//   MIN_SPACING       low time after each command (min 2)
//   CMD_WIDTH         high time of each command (min 1)
//   RESYNC_EVERY      auto resync interval in triggers, 0 = never
//   TRIGGER_DISABLED  generator cannot accept triggers: new requests dropped
//   CNT_CLR           synchronous clear of both counters
//   TRIG_CMD          trigger command to generator
//   RESET_CMD         reset command to generator
//   BUSY              sequencer not idle
//   LAST_SRC          source of the last issued trigger
//   ISSUED_CNT        triggers issued (wraps)
//   DROPPED_CNT       requests dropped (wraps)
// ---------------------------------------------------------------------------
module apv_trig_sequencer
    import trig_seq_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int PULSER_W = 24,
    parameter int HOLD_W   = 8
) (
    input  logic                CLK,
    input  logic                RSTb,
    input  logic [2:0]          SRC_EN,
    input  logic                EXT_TRIG,
    input  logic                SW_TRIG,
    input  logic                SW_RESET,
    input  logic [PULSER_W-1:0] PULSER_PERIOD,
    input  logic [HOLD_W-1:0]   MIN_SPACING,
    input  logic [3:0]          CMD_WIDTH,
    input  logic [15:0]         RESYNC_EVERY,
    input  logic                TRIGGER_DISABLED,
    input  logic                CNT_CLR,
    output logic                TRIG_CMD,
    output logic                RESET_CMD,
    output logic                BUSY,
    output logic [1:0]          LAST_SRC,
    output logic [CNT_W-1:0]    ISSUED_CNT,
    output logic [CNT_W-1:0]    DROPPED_CNT
);

    // One extra bit, so that hold_cnt+1 cannot overflow against a limit of 255.
    localparam int LW = HOLD_W + 1;

    seq_state_t           state, state_nxt;

    logic                 ext_s1, ext_s2, ext_d;
    logic                 ext_edge;
    logic                 pulser_tick;

    logic [NUM_SRC-1:0]   req, pend, grant, accept, drop;
    logic [1:0]           n_drop;
    logic                 issue;
    src_id_t              sel;

    logic                 rst_pend;
    logic [15:0]          resync_cnt;
    logic                 resync_due;

    logic [HOLD_W-1:0]    hold_cnt;
    logic [LW-1:0]        cmd_lim, spc_lim, phase_lim;
    logic                 phase_done;
    logic                 rst_done;

    // ---------------- request sources ----------------
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            ext_s1 <= 1'b0;
            ext_s2 <= 1'b0;
            ext_d  <= 1'b0;
        end else begin
            ext_s1 <= EXT_TRIG;
            ext_s2 <= ext_s1;
            ext_d  <= ext_s2;
        end
    end

    assign ext_edge = ext_s2 && !ext_d;

    trig_pulser #(.PULSER_W(PULSER_W)) u_pulser (
        .gclk   (CLK),
        .grst_n (RSTb),
        .enable (SRC_EN[SRC_PULSER]),
        .period (PULSER_PERIOD),
        .tick   (pulser_tick)
    );

    assign req[SRC_EXT]    = ext_edge;
    assign req[SRC_SW]     = SW_TRIG;
    assign req[SRC_PULSER] = pulser_tick;

    // ---------------- arbitration ----------------
    // A pending reset blocks trigger grants. The trigger stays pending
    // until the resync sequence completes.
    assign sel   = pick_src(pend);
    assign issue = (state == ST_IDLE) && !rst_pend && (pend != '0);

    always_comb begin
        grant = '0;
        if (issue)
            grant = NUM_SRC'(1) << sel;
    end

    // A flag consumed this cycle counts as free. A request that lands
    // on the grant cycle is latched, not dropped.
    always_comb begin
        n_drop = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            accept[i] = SRC_EN[i] && req[i] && !TRIGGER_DISABLED && (!pend[i] || grant[i]);
            drop[i]   = SRC_EN[i] && req[i] && !accept[i];
            n_drop    = n_drop + 2'(drop[i]);
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!SRC_EN[i])
                    pend[i] <= 1'b0;
                else if (accept[i])
                    pend[i] <= 1'b1;
                else if (grant[i])
                    pend[i] <= 1'b0;
            end
        end
    end

    // ---------------- phase timing ----------------
    // Limits are sampled live. hold_cnt counts elapsed cycles, so a change
    // mid-phase only moves the end of the phase.
    assign cmd_lim = (CMD_WIDTH == 4'd0) ? LW'(1) : LW'(CMD_WIDTH);
    assign spc_lim = (MIN_SPACING < HOLD_W'(MIN_LOW)) ? LW'(MIN_LOW) : LW'(MIN_SPACING);

    always_comb begin
        phase_lim = spc_lim;
        if (state == ST_TRIG_HI || state == ST_RST_HI)
            phase_lim = cmd_lim;
    end

    assign phase_done = (LW'(hold_cnt) + LW'(1)) >= phase_lim;
    assign rst_done   = (state == ST_RST_HI) && phase_done;
    assign resync_due = (RESYNC_EVERY != 16'd0) && (resync_cnt >= RESYNC_EVERY);

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb)
            hold_cnt <= '0;
        else if (state == ST_IDLE || phase_done)
            hold_cnt <= '0;
        else
            hold_cnt <= hold_cnt + HOLD_W'(1);
    end

    // ---------------- FSM ----------------
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (rst_pend)
                    state_nxt = ST_RST_HI;
                else if (issue)
                    state_nxt = ST_TRIG_HI;
            end
            ST_TRIG_HI: if (phase_done) state_nxt = ST_TRIG_LO;
            ST_TRIG_LO: if (phase_done) state_nxt = resync_due ? ST_RST_HI : ST_IDLE;
            ST_RST_HI:  if (phase_done) state_nxt = ST_RST_LO;
            ST_RST_LO:  if (phase_done) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Commands decode straight from the state register. An async reset
    // therefore drops them at once.
    always_comb begin
        TRIG_CMD  = 1'b0;
        RESET_CMD = 1'b0;
        BUSY      = 1'b1;
        unique case (state)
            ST_IDLE:    BUSY      = 1'b0;
            ST_TRIG_HI: TRIG_CMD  = 1'b1;
            ST_RST_HI:  RESET_CMD = 1'b1;
            default:    ;
        endcase
    end

    // ---------------- resync bookkeeping ----------------
    // A SW_RESET that lands on the clearing edge wins, so it is never lost.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            rst_pend   <= 1'b0;
            resync_cnt <= '0;
        end else begin
            if (SW_RESET)
                rst_pend <= 1'b1;
            else if (rst_done)
                rst_pend <= 1'b0;

            if (rst_done)
                resync_cnt <= '0;
            else if (issue)
                resync_cnt <= resync_cnt + 16'd1;
        end
    end

    // ---------------- status / counters ----------------
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            LAST_SRC    <= '0;
            ISSUED_CNT  <= '0;
            DROPPED_CNT <= '0;
        end else begin
            if (issue)
                LAST_SRC <= sel;
            if (CNT_CLR) begin
                ISSUED_CNT  <= '0;
                DROPPED_CNT <= '0;
            end else begin
                if (issue)
                    ISSUED_CNT <= ISSUED_CNT + CNT_W'(1);
                DROPPED_CNT <= DROPPED_CNT + CNT_W'(n_drop);
            end
        end
    end

endmodule

// File: tb/tb_apv_trig_sequencer.sv
// ---------------------------------------------------------------------------
// tb_apv_trig_sequencer
//   Randomized and directed stimulus. Each cycle is checked against a
//   schedule-based reference model. When a command is granted, the model
//   books the whole high/low (and resync) window as absolute cycle ranges.
//   Cycle 0 is the first cycle after reset release.
// ---------------------------------------------------------------------------
module tb_apv_trig_sequencer;

    localparam int CNT_W    = 32;
    localparam int PULSER_W = 24;
    localparam int HOLD_W   = 8;

    logic                CLK = 1'b0;
    logic                RSTb;
    logic [2:0]          SRC_EN;
    logic                EXT_TRIG, SW_TRIG, SW_RESET, TRIGGER_DISABLED, CNT_CLR;
    logic [PULSER_W-1:0] PULSER_PERIOD;
    logic [HOLD_W-1:0]   MIN_SPACING;
    logic [3:0]          CMD_WIDTH;
    logic [15:0]         RESYNC_EVERY;
    logic                TRIG_CMD, RESET_CMD, BUSY;
    logic [1:0]          LAST_SRC;
    logic [CNT_W-1:0]    ISSUED_CNT, DROPPED_CNT;

    always #5 CLK = ~CLK;

    apv_trig_sequencer #(.CNT_W(CNT_W), .PULSER_W(PULSER_W), .HOLD_W(HOLD_W)) dut (
        .CLK              (CLK),
        .RSTb             (RSTb),
        .SRC_EN           (SRC_EN),
        .EXT_TRIG         (EXT_TRIG),
        .SW_TRIG          (SW_TRIG),
        .SW_RESET         (SW_RESET),
        .PULSER_PERIOD    (PULSER_PERIOD),
        .MIN_SPACING      (MIN_SPACING),
        .CMD_WIDTH        (CMD_WIDTH),
        .RESYNC_EVERY     (RESYNC_EVERY),
        .TRIGGER_DISABLED (TRIGGER_DISABLED),
        .CNT_CLR          (CNT_CLR),
        .TRIG_CMD         (TRIG_CMD),
        .RESET_CMD        (RESET_CMD),
        .BUSY             (BUSY),
        .LAST_SRC         (LAST_SRC),
        .ISSUED_CNT       (ISSUED_CNT),
        .DROPPED_CNT      (DROPPED_CNT)
    );

    int n_vec = 0;
    int n_err = 0;

    // staged configuration, applied to the DUT in step()
    logic [2:0]  cfg_en  = 3'b000;
    logic [23:0] cfg_per = 24'd0;
    logic [7:0]  cfg_sp  = 8'd4;
    logic [3:0]  cfg_w   = 4'd3;
    logic [15:0] cfg_rs  = 16'd0;
    logic        cfg_dis = 1'b0;
    logic        ext_lvl = 1'b0;

    // reference model
    int          cyc, trig_s, trig_e, rst_s, rst_e, idle_from, rclr_at, m_pcnt;
    logic [2:0]  m_flag;
    logic        m_rpend;
    logic [1:0]  m_last;
    logic [31:0] m_issued, m_dropped;
    logic [15:0] m_resync;
    logic        h1, h2, h3;   // EXT level 1, 2, 3 cycles ago

    // observed command edges
    logic        p_trig, p_rst;
    int          trig_rises, rst_rises, rise_last, rise_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h want %0h", tag, cyc, got, want);
        end
    endtask

    task automatic drive_cfg();
        SRC_EN           = cfg_en;
        PULSER_PERIOD    = cfg_per;
        MIN_SPACING      = cfg_sp;
        CMD_WIDTH        = cfg_w;
        RESYNC_EVERY     = cfg_rs;
        TRIGGER_DISABLED = cfg_dis;
        EXT_TRIG         = ext_lvl;
    endtask

    task automatic do_reset();
        RSTb     = 1'b0;
        SW_TRIG  = 1'b0;
        SW_RESET = 1'b0;
        CNT_CLR  = 1'b0;
        ext_lvl  = 1'b0;
        drive_cfg();
        #1;
        chk("rst_trig",    32'(TRIG_CMD),  32'd0);
        chk("rst_reset",   32'(RESET_CMD), 32'd0);
        chk("rst_busy",    32'(BUSY),      32'd0);
        chk("rst_last",    32'(LAST_SRC),  32'd0);
        chk("rst_issued",  ISSUED_CNT,     32'd0);
        chk("rst_dropped", DROPPED_CNT,    32'd0);
        cyc = 0; trig_s = -10; trig_e = -10; rst_s = -10; rst_e = -10;
        idle_from = 0; rclr_at = -1; m_pcnt = 0;
        m_flag = '0; m_rpend = 1'b0; m_last = '0; m_issued = '0; m_dropped = '0; m_resync = '0;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        p_trig = 1'b0; p_rst = 1'b0; trig_rises = 0; rst_rises = 0; rise_last = -1; rise_prev = -1;
        repeat (2) @(negedge CLK);
        RSTb = 1'b1;
    endtask

    // One clock cycle. Called at a negedge: check this cycle's outputs,
    // drive this cycle's inputs, advance the model across the next posedge.
    task automatic step(input logic sw, input logic srst, input logic clr);
        int         w, s, g, nd;
        logic [2:0] req, grant;
        logic       acc;
        chk("trig",    32'(TRIG_CMD),  32'(cyc >= trig_s && cyc <= trig_e));
        chk("reset",   32'(RESET_CMD), 32'(cyc >= rst_s && cyc <= rst_e));
        chk("busy",    32'(BUSY),      32'(cyc < idle_from));
        chk("last",    32'(LAST_SRC),  32'(m_last));
        chk("issued",  ISSUED_CNT,     m_issued);
        chk("dropped", DROPPED_CNT,    m_dropped);
        if (TRIG_CMD === 1'b1 && !p_trig) begin
            trig_rises++; rise_prev = rise_last; rise_last = cyc;
        end
        if (RESET_CMD === 1'b1 && !p_rst) rst_rises++;
        p_trig = (TRIG_CMD === 1'b1);
        p_rst  = (RESET_CMD === 1'b1);

        drive_cfg();
        SW_TRIG  = sw;
        SW_RESET = srst;
        CNT_CLR  = clr;

        w = (cfg_w == 4'd0) ? 1 : int'(cfg_w);
        s = (cfg_sp < 8'd2) ? 2 : int'(cfg_sp);
        req[0] = h2 && !h3;
        req[1] = sw;
        req[2] = cfg_en[2] && (cfg_per != 24'd0) && (m_pcnt >= int'(cfg_per) - 1);
        grant  = '0;
        if (cyc >= idle_from) begin
            if (m_rpend) begin
                rst_s = cyc + 1; rst_e = cyc + w; rclr_at = rst_e;
                idle_from = rst_e + s + 1;
            end else if (m_flag != 3'b000) begin
                g = m_flag[0] ? 0 : (m_flag[1] ? 1 : 2);
                grant[g] = 1'b1;
                trig_s = cyc + 1; trig_e = cyc + w;
                m_last = 2'(g);
                if (!clr) m_issued = m_issued + 1;
                m_resync = m_resync + 16'd1;
                if (cfg_rs != 16'd0 && m_resync >= cfg_rs) begin
                    rst_s = trig_e + s + 1; rst_e = rst_s + w - 1; rclr_at = rst_e;
                    idle_from = rst_e + s + 1;
                end else begin
                    idle_from = trig_e + s + 1;
                end
            end
        end
        nd = 0;
        for (int i = 0; i < 3; i++) begin
            acc = cfg_en[i] && req[i] && !cfg_dis && (!m_flag[i] || grant[i]);
            if (cfg_en[i] && req[i] && !acc) nd++;
            if (!cfg_en[i])    m_flag[i] = 1'b0;
            else if (acc)      m_flag[i] = 1'b1;
            else if (grant[i]) m_flag[i] = 1'b0;
        end
        if (clr) begin
            m_issued = '0; m_dropped = '0;
        end else begin
            m_dropped = m_dropped + 32'(nd);
        end
        if (cyc == rclr_at) begin
            m_rpend = srst; m_resync = '0;
        end else if (srst) begin
            m_rpend = 1'b1;
        end
        m_pcnt = (!cfg_en[2] || cfg_per == 24'd0 || req[2]) ? 0 : m_pcnt + 1;
        h3 = h2; h2 = h1; h1 = ext_lvl;

        @(negedge CLK);
        cyc++;
    endtask

    task automatic drain();
        cfg_en = 3'b000;
        for (int k = 0; k < 600 && cyc < idle_from; k++) step(1'b0, 1'b0, 1'b0);
        chk("drain_idle", 32'(BUSY), 32'd0);
    endtask

    initial begin
        // 1: single software trigger timing
        cfg_en = 3'b010; cfg_w = 4'd3; cfg_sp = 8'd4; cfg_rs = 16'd0; cfg_per = 24'd0; cfg_dis = 1'b0;
        do_reset();
        for (int k = 0; k < 22; k++) step(k == 10, 1'b0, 1'b0);
        chk("t1_rise",   32'(rise_last),  32'd12);
        chk("t1_rises",  32'(trig_rises), 32'd1);
        chk("t1_issued", ISSUED_CNT,      32'd1);
        chk("t1_last",   32'(LAST_SRC),   32'd1);

        // 2: back-to-back sw, then one while pending
        do_reset();
        for (int k = 0; k < 25; k++) step(k == 2 || k == 3 || k == 5, 1'b0, 1'b0);
        chk("t2_rises",   32'(trig_rises), 32'd2);
        chk("t2_gap",     32'(rise_last - rise_prev >= 3 + 4), 32'd1);
        chk("t2_dropped", DROPPED_CNT,     32'd1);

        // 3: pulser period 100, then off
        cfg_en = 3'b100; cfg_per = 24'd100;
        do_reset();
        for (int k = 0; k < 320; k++) step(1'b0, 1'b0, 1'b0);
        chk("t3_rises", 32'(trig_rises), 32'd3);
        chk("t3_gap",   32'(rise_last - rise_prev), 32'd100);
        cfg_per = 24'd0;
        for (int k = 0; k < 200; k++) step(1'b0, 1'b0, 1'b0);
        chk("t3_off", 32'(trig_rises), 32'd3);

        // 4: resync every 2 triggers, five triggers
        cfg_en = 3'b010; cfg_rs = 16'd2;
        do_reset();
        for (int k = 0; k < 160; k++) step(k % 30 == 5 && k < 150, 1'b0, 1'b0);
        chk("t4_trig",  32'(trig_rises), 32'd5);
        chk("t4_reset", 32'(rst_rises),  32'd2);
        cfg_rs = 16'd0;

        // 5: disabled, all three sources requesting in the same cycle
        cfg_en = 3'b111; cfg_per = 24'd5; cfg_dis = 1'b1;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (k == 2) ext_lvl = 1'b1;
            if (k == 5) cfg_per = 24'd0;
            step(k == 4, 1'b0, 1'b0);
        end
        chk("t5_dropped", DROPPED_CNT,     32'd3);
        chk("t5_rises",   32'(trig_rises), 32'd0);
        cfg_dis = 1'b0;

        // 6: async reset during TRIG_HI
        cfg_en = 3'b010;
        do_reset();
        for (int k = 0; k < 5; k++) step(k == 2, 1'b0, 1'b0);
        chk("t6_pre", 32'(TRIG_CMD), 32'd1);
        do_reset();
        for (int k = 0; k < 15; k++) step(k == 2, 1'b0, 1'b0);
        chk("t6_rise",   32'(rise_last), 32'd4);
        chk("t6_issued", ISSUED_CNT,     32'd1);

        // random segments; config changes only while idle
        for (int seg = 0; seg < 14; seg++) begin
            drain();
            cfg_en  = 3'($urandom);
            cfg_per = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 40));
            cfg_w   = 4'($urandom_range(0, 4));
            cfg_sp  = 8'($urandom_range(0, 6));
            cfg_rs  = 16'($urandom_range(0, 3));
            for (int k = 0; k < 200; k++) begin
                if ($urandom_range(0, 5) == 0) ext_lvl = ~ext_lvl;
                cfg_dis = ($urandom_range(0, 9) == 0);
                step($urandom_range(0, 6) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 99) == 0);
            end
        end
        cfg_dis = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
